// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ready handshake with
// a timeout, holds the fetched word for decode and advances the PC at retire.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrc,
  input  logic [31:0] ImmExt,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  Op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, ERROR} state_t;

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [15:0] cnt_q;
  logic        err_q;
  logic [31:0] pc_d;

  assign pc_d = PCSrc ? (pc_q + ImmExt) : (pc_q + 32'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            cnt_q   <= '0;
            state_q <= VALID;
          end else if (cnt_q == TIMEOUT_LAST) begin
            err_q   <= 1'b1;
            state_q <= ERROR;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        VALID: begin
          if (retire) begin
            // A misaligned target is fatal; the PC keeps the faulting instruction's address.
            if (pc_d[1:0] != 2'b00) begin
              err_q   <= 1'b1;
              state_q <= ERROR;
            end else begin
              pc_q    <= pc_d;
              state_q <= FETCH;
            end
          end
        end
        ERROR:   state_q <= ERROR;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == VALID);
  assign instr       = instr_q;
  assign Op          = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7      = instr_q[31:25];
  assign PC          = pc_q;
  assign PCPlus4     = pc_q + 32'd4;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table for the
// zero-wait/branch flow plus hand sequences for wait states, errors and reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrc;
  logic [31:0] ImmExt;
  logic        retire;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  Op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  localparam logic [31:0] D0 = 32'h0050_0093, D1 = 32'h4020_8133, D2 = 32'h0041_A183;
  localparam logic [31:0] D3 = 32'hFE20_9EE3, D4 = 32'h00C0_0213, D5 = 32'h02A2_82B3;
  localparam logic [31:0] D6 = 32'h0000_0063, D7 = 32'hABCD_E037;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .ImmExt(ImmExt), .retire(retire),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr), .Op(Op),
    .funct3(funct3), .funct7(funct7), .PC(PC), .PCPlus4(PCPlus4), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic [31:0] rdata;
    logic        ret;
    logic        pcsrc;
    logic [31:0] imm;
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rdy, input logic [31:0] rd, input logic rt,
                              input logic ps, input logic [31:0] im, input logic er,
                              input logic ev, input logic [31:0] ep, input logic [31:0] ei,
                              input logic ee);
    vec_t v;
    v.ready = rdy; v.rdata = rd; v.ret = rt; v.pcsrc = ps; v.imm = im;
    v.exp_req = er; v.exp_valid = ev; v.exp_pc = ep; v.exp_instr = ei; v.exp_err = ee;
    return v;
  endfunction

  task automatic idle_inputs();
    imem_ready = 1'b0; imem_rdata = JUNK; retire = 1'b0; PCSrc = 1'b0; ImmExt = 32'd0;
  endtask

  // Holds rst for two cycles, checks the reset state, releases on a falling edge.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", PC, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0]  = mk(1, JUNK, 1, 1, 32'd4,        0, 0, 32'h00, NOP, 0);
    vecs[1]  = mk(1, D0,   1, 1, 32'd8,        1, 0, 32'h00, NOP, 0);
    vecs[2]  = mk(1, JUNK, 1, 0, 32'd0,        0, 1, 32'h00, D0,  0);
    vecs[3]  = mk(1, D1,   0, 0, 32'd0,        1, 0, 32'h04, D0,  0);
    vecs[4]  = mk(1, JUNK, 1, 0, 32'd0,        0, 1, 32'h04, D1,  0);
    vecs[5]  = mk(1, D2,   0, 0, 32'd0,        1, 0, 32'h08, D1,  0);
    vecs[6]  = mk(1, JUNK, 0, 0, 32'd0,        0, 1, 32'h08, D2,  0);
    vecs[7]  = mk(1, JUNK, 1, 0, 32'd0,        0, 1, 32'h08, D2,  0);
    vecs[8]  = mk(1, D3,   0, 0, 32'd0,        1, 0, 32'h0C, D2,  0);
    vecs[9]  = mk(1, JUNK, 1, 0, 32'd0,        0, 1, 32'h0C, D3,  0);
    vecs[10] = mk(1, D4,   0, 0, 32'd0,        1, 0, 32'h10, D3,  0);
    vecs[11] = mk(1, JUNK, 1, 0, 32'hFFFF_FFF8, 0, 1, 32'h10, D4,  0);
    vecs[12] = mk(1, D5,   0, 0, 32'd0,        1, 0, 32'h14, D4,  0);
    vecs[13] = mk(1, JUNK, 1, 1, 32'hFFFF_FFFC, 0, 1, 32'h14, D5,  0);
    vecs[14] = mk(1, D6,   0, 0, 32'd0,        1, 0, 32'h10, D5,  0);
    vecs[15] = mk(1, JUNK, 1, 1, 32'hFFFF_FFF8, 0, 1, 32'h10, D6,  0);
    vecs[16] = mk(1, D7,   0, 0, 32'd0,        1, 0, 32'h08, D6,  0);
    vecs[17] = mk(1, JUNK, 0, 0, 32'd0,        0, 1, 32'h08, D7,  0);

    // Zero-wait flow with sequential, not-taken and taken (backward) branches.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_pc", i), PC, vecs[i].exp_pc);
      chk($sformatf("v%0d_pc4", i), PCPlus4, vecs[i].exp_pc + 32'd4);
      chk($sformatf("v%0d_instr", i), instr, vecs[i].exp_instr);
      chk($sformatf("v%0d_err", i), 32'(fetch_err), 32'(vecs[i].exp_err));
      if (vecs[i].exp_req) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_pc);
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_op", i), 32'(Op), 32'(vecs[i].exp_instr[6:0]));
        chk($sformatf("v%0d_f3", i), 32'(funct3), 32'(vecs[i].exp_instr[14:12]));
        chk($sformatf("v%0d_f7", i), 32'(funct7), 32'(vecs[i].exp_instr[31:25]));
      end
      imem_ready = vecs[i].ready; imem_rdata = vecs[i].rdata;
      retire = vecs[i].ret; PCSrc = vecs[i].pcsrc; ImmExt = vecs[i].imm;
      @(negedge clk);
    end
    $display("zero-wait table done: checks=%0d failures=%0d", checks, failures);

    // Five wait states, then the ready cycle.
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ws%0d_req", k), 32'(imem_req), 32'd1);
      chk($sformatf("ws%0d_addr", k), imem_addr, 32'd0);
      chk($sformatf("ws%0d_valid", k), 32'(instr_valid), 32'd0);
      @(negedge clk);
    end
    chk("ws_ready_req", 32'(imem_req), 32'd1);
    imem_ready = 1'b1; imem_rdata = D1;
    @(negedge clk);
    imem_ready = 1'b0; imem_rdata = JUNK;
    chk("ws_valid", 32'(instr_valid), 32'd1);
    chk("ws_instr", instr, D1);
    chk("ws_err", 32'(fetch_err), 32'd0);
    $display("wait-state fetch done: instr=%h err=%0d", instr, fetch_err);

    // Retire, then never answer: expect exactly 16 FETCH cycles before ERROR.
    retire = 1'b1;
    @(negedge clk);
    retire = 1'b0;
    n = 0;
    while (imem_req && n < 40) begin
      chk($sformatf("to%0d_addr", n), imem_addr, 32'd4);
      n++;
      @(negedge clk);
    end
    chk("to_cycles", 32'(n), 32'd16);
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_valid", 32'(instr_valid), 32'd0);
    retire = 1'b1; PCSrc = 1'b1; ImmExt = 32'h100; imem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("err%0d_req", k), 32'(imem_req), 32'd0);
      chk($sformatf("err%0d_pc", k), PC, 32'd4);
      chk($sformatf("err%0d_err", k), 32'(fetch_err), 32'd1);
      chk($sformatf("err%0d_instr", k), instr, D1);
    end
    $display("timeout done: fetch cycles=%0d err=%0d", n, fetch_err);

    // Misaligned branch target.
    do_reset();
    imem_ready = 1'b1; imem_rdata = D0;
    @(negedge clk);
    @(negedge clk);
    imem_ready = 1'b0;
    chk("mis_valid_before", 32'(instr_valid), 32'd1);
    retire = 1'b1; PCSrc = 1'b1; ImmExt = 32'd6;
    @(negedge clk);
    retire = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mis%0d_err", k), 32'(fetch_err), 32'd1);
      chk($sformatf("mis%0d_pc", k), PC, 32'd0);
      chk($sformatf("mis%0d_req", k), 32'(imem_req), 32'd0);
      chk($sformatf("mis%0d_valid", k), 32'(instr_valid), 32'd0);
      @(negedge clk);
    end
    $display("misaligned done: pc=%h err=%0d", PC, fetch_err);

    // Asynchronous reset mid-fetch, coinciding with a memory response.
    do_reset();
    imem_ready = 1'b1; imem_rdata = D0; PCSrc = 1'b0; ImmExt = 32'd0;
    @(negedge clk);
    @(negedge clk);
    retire = 1'b1;
    @(negedge clk);
    retire = 1'b0;
    chk("ar_pre_req", 32'(imem_req), 32'd1);
    chk("ar_pre_addr", imem_addr, 32'd4);
    imem_rdata = D1; rst = 1'b1;
    #1;
    chk("ar_pc", PC, 32'd0);
    chk("ar_instr", instr, NOP);
    chk("ar_valid", 32'(instr_valid), 32'd0);
    chk("ar_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("ar_rel_req", 32'(imem_req), 32'd0);
    chk("ar_rel_instr", instr, NOP);
    @(negedge clk);
    chk("ar_restart_req", 32'(imem_req), 32'd1);
    chk("ar_restart_addr", imem_addr, 32'd0);
    $display("async reset done: pc=%h instr=%h", PC, instr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
